sweep_ctrl: RTL and testbench
=============================

Name: sweep_ctrl

Overview:
Sequencer for the 4-bit up/down counter datapath: owns the count register and drives its direction so that q sweeps between programmed bounds lo and hi for a programmed number of round trips. A single start request launches a sweep. Progress is reported by busy/done/err, and an abort input cancels the sweep. Sits between a control FSM or host register block and any logic consuming the count.

Parameters:
WIDTH, 4, counter/bound width in bits
PASS_W, 3, width of the pass-count input

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request a sweep; sampled only in IDLE
abort  input  1  cancel sweep; priority over start
lo  input  WIDTH  lower bound, latched on accepted start
hi  input  WIDTH  upper bound, latched on accepted start
passes  input  PASS_W  number of round trips lo->hi->lo, latched on start
q  output  WIDTH  current count
dir  output  1  1 = counting up, 0 = counting down
busy  output  1  high while state != IDLE
done  output  1  one-cycle pulse on sweep completion
err  output  1  one-cycle pulse on rejected start

Behaviour:
- Reset (reset=0, async): state=IDLE, q=0, dir=1, busy=0, done=0, err=0, pass counter=0, latched bounds=0.
- States: IDLE, UP, DOWN, DONE. busy = (state != IDLE).
- Start in IDLE with abort=0:
  - If lo>=hi or passes==0: err=1 for one cycle, state stays IDLE, q unchanged.
  - Otherwise, at the same edge: latch lo/hi/passes, q<=lo, dir<=1, pass counter<=0, state<=UP.
- UP, each edge: q<=q+1. If q+1==hi, then dir<=0 and state<=DOWN. q therefore holds hi for exactly one cycle.
- DOWN, each edge: q<=q-1. If q-1==lo, the pass is complete and the pass counter increments.
  - If the incremented count == passes: state<=DONE.
  - Otherwise: dir<=1 and state<=UP.
- DONE: done=1 for this one cycle, q held at lo. Next edge: state<=IDLE, dir<=1.
- Timing: let D=hi-lo and P=passes. Busy lasts 2*D*P+1 cycles. Done is asserted in the last busy cycle.
- Arithmetic: no wrap occurs in normal operation because lo<hi. q is held in IDLE.
- abort=1 in UP/DOWN/DONE: next edge state<=IDLE, q holds its current value, dir<=1, no done pulse. In IDLE, abort suppresses start, including err.
- start while busy: ignored. Bound and passes inputs are don't-care except at accepted start.
- Reset mid-sweep: immediate return to reset values. No done is produced.

Optional Feature:
SWEEP_HOLD_EN
- Defined: adds input port hold (1 bit). While busy and hold=1, q, dir, state and the pass counter freeze; abort still wins over hold.
- Undefined: no hold port; sweeps run uninterrupted.

Decomposition:
- Package sweep_pkg:
  - typedef enum logic [1:0] sweep_state_t {IDLE, UP, DOWN, DONE}
  - constants SWEEP_WIDTH=4 and SWEEP_PASS_W=3
- Sub-module updown_cnt: WIDTH-bit register with en, load, load_val and dir inputs, async active-low reset to 0. It holds q. sweep_ctrl contains the FSM, the bound/pass registers and the compare logic.

Test Plan:
- Reset then lo=2, hi=5, passes=1, start pulse: q = 2,3,4,5,4,3,2. dir falls in the cycle q=5. busy lasts 7 cycles, done in the 7th; then IDLE with q=2.
- lo=2, hi=5, passes=2: q traces 2..5..2..5..2. busy lasts 13 cycles, single done pulse, no done at the first return to 2.
- lo=7, hi=7, passes=1 start: err=1 for one cycle, busy stays 0, q unchanged. Same result for lo=0, hi=15, passes=0.
- lo=0, hi=15, passes=7, abort asserted when q=9 in UP: next cycle busy=0, q=9, dir=1, no done. Start with abort=1 in IDLE: nothing happens.
- reset driven low asynchronously mid-DOWN at q=6: q=0, busy=0 immediately without a clock. A start after reset release runs a normal sweep.
- With SWEEP_HOLD_EN, lo=1, hi=4, passes=1, hold high for 3 cycles at q=3 in UP: q stays 3 with busy=1 during the hold, then the sweep resumes. busy lasts 7+3 cycles total.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and default sizes for the sweep sequencer.
package sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UP   = 2'd1,
      DOWN = 2'd2,
      DONE = 2'd3
   } sweep_state_t;

   localparam int SWEEP_WIDTH  = 4;
   localparam int SWEEP_PASS_W = 3;

endpackage

// File: rtl/sweep_ctrl_updown_cnt.sv
// Loadable up/down counter register; load beats count, reset clears to zero.
module updown_cnt
   import sweep_pkg::*;
#(
   parameter int WIDTH = SWEEP_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dir,
   output logic [WIDTH-1:0] q
);

   // count register: load has priority, otherwise step in dir when enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (load) q <= load_val;
      else if (en)   q <= dir ? q + WIDTH'(1) : q - WIDTH'(1);
   end

endmodule

// File: rtl/sweep_ctrl.sv
// Sweep sequencer: drives updown_cnt between latched lo/hi for a latched
// number of round trips. Optional macro SWEEP_HOLD_EN adds a 'hold' input
// that freezes a running sweep (abort still wins).
module sweep_ctrl
   import sweep_pkg::*;
#(
   parameter int WIDTH  = SWEEP_WIDTH,
   parameter int PASS_W = SWEEP_PASS_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
`ifdef SWEEP_HOLD_EN
   input  logic              hold,
`endif
   input  logic [WIDTH-1:0]  lo,
   input  logic [WIDTH-1:0]  hi,
   input  logic [PASS_W-1:0] passes,
   output logic [WIDTH-1:0]  q,
   output logic              dir,
   output logic              busy,
   output logic              done,
   output logic              err
);

   sweep_state_t      state;
   logic [WIDTH-1:0]  lo_r, hi_r;
   logic [PASS_W-1:0] passes_r, pcnt;

   logic              frz;
   logic              start_req, start_bad, start_ok;
   logic              run, cnt_en;
   logic [WIDTH-1:0]  q_inc, q_dec;
   logic [PASS_W-1:0] pcnt_inc;

`ifdef SWEEP_HOLD_EN
   assign frz = hold;
`else
   assign frz = 1'b0;
`endif

   // start is only looked at in IDLE, and abort masks it completely
   assign start_req = (state == IDLE) && start && !abort;
   assign start_bad = (lo >= hi) || (passes == '0);
   assign start_ok  = start_req && !start_bad;

   assign run      = (state == UP) || (state == DOWN);
   assign cnt_en   = run && !abort && !frz;
   assign q_inc    = q + WIDTH'(1);
   assign q_dec    = q - WIDTH'(1);
   assign pcnt_inc = pcnt + PASS_W'(1);

   updown_cnt #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst_n    (reset),
      .en       (cnt_en),
      .load     (start_ok),
      .load_val (lo),
      .dir      (state == UP),
      .q        (q)
   );

   // sequencing FSM with registered busy/done/err/dir
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         dir      <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         pcnt     <= '0;
         lo_r     <= '0;
         hi_r     <= '0;
         passes_r <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (state == IDLE) begin
            if (start_req && start_bad) begin
               err <= 1'b1;
            end else if (start_ok) begin
               lo_r     <= lo;
               hi_r     <= hi;
               passes_r <= passes;
               pcnt     <= '0;
               dir      <= 1'b1;
               busy     <= 1'b1;
               state    <= UP;
            end
         end else if (abort) begin
            state <= IDLE;
            dir   <= 1'b1;
            busy  <= 1'b0;
         end else if (frz) begin
            // a frozen DONE keeps its pulse up until released
            done <= (state == DONE);
         end else begin
            case (state)
               UP: begin
                  if (q_inc == hi_r) begin
                     dir   <= 1'b0;
                     state <= DOWN;
                  end
               end
               DOWN: begin
                  if (q_dec == lo_r) begin
                     pcnt <= pcnt_inc;
                     if (pcnt_inc == passes_r) begin
                        done  <= 1'b1;
                        state <= DONE;
                     end else begin
                        dir   <= 1'b1;
                        state <= UP;
                     end
                  end
               end
               DONE: begin
                  dir   <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sweep_ctrl.sv
// Directed bench for sweep_ctrl: vector table plus hand sequences for
// trace, abort, async reset and (when SWEEP_HOLD_EN is defined) hold.
module tb_sweep_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       hold = 1'b0;
   logic [3:0] lo = '0, hi = '0;
   logic [2:0] passes = '0;
   logic [3:0] q;
   logic       dir, busy, done, err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sweep_ctrl #(.WIDTH(4), .PASS_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .abort  (abort),
`ifdef SWEEP_HOLD_EN
      .hold   (hold),
`endif
      .lo     (lo),
      .hi     (hi),
      .passes (passes),
      .q      (q),
      .dir    (dir),
      .busy   (busy),
      .done   (done),
      .err    (err)
   );

   typedef struct {
      logic [3:0] lo;
      logic [3:0] hi;
      logic [2:0] p;
      int         exp_busy;
      int         exp_done;
      int         exp_err;
      int         exp_q;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // pulse start with the given config, then observe until idle for 2 cycles
   task automatic run_vec(input logic [3:0] l, input logic [3:0] h, input logic [2:0] p,
                          output int nbusy, output int ndone, output int nerr,
                          output int done_at);
      int idle;
      nbusy = 0; ndone = 0; nerr = 0; done_at = -1; idle = 0;
      @(negedge clk);
      lo = l; hi = h; passes = p; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (busy) begin
            nbusy++;
            idle = 0;
            if (done) done_at = nbusy;
         end else begin
            idle++;
         end
         if (done) ndone++;
         if (err) nerr++;
         if (idle >= 2) break;
         if (c == 399) chk("run_vec_timeout", 1, 0);
         @(negedge clk);
      end
   endtask

   initial begin
      int nb, nd, ne, da;
      logic [3:0] qexp[7];
      logic       dexp[7];
      bit         found;

      qexp = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
      dexp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

      //         lo  hi  p  busy done err q
      tbl[0] = '{4'd2, 4'd5,  3'd1,  7, 1, 0, 2};
      tbl[1] = '{4'd2, 4'd5,  3'd2, 13, 1, 0, 2};
      tbl[2] = '{4'd7, 4'd7,  3'd1,  0, 0, 1, 2};
      tbl[3] = '{4'd0, 4'd15, 3'd0,  0, 0, 1, 2};
      tbl[4] = '{4'd0, 4'd1,  3'd1,  3, 1, 0, 0};
      tbl[5] = '{4'd9, 4'd4,  3'd2,  0, 0, 1, 0};
      tbl[6] = '{4'd3, 4'd9,  3'd3, 37, 1, 0, 3};
      tbl[7] = '{4'd14, 4'd15, 3'd7, 15, 1, 0, 14};

      // reset values
      #12;
      chk("rst_q", q, 0);
      chk("rst_dir", dir, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      reset = 1'b1;

      // cycle trace for lo=2 hi=5 passes=1
      @(negedge clk);
      lo = 4'd2; hi = 4'd5; passes = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("trace_q%0d", i), q, qexp[i]);
         chk($sformatf("trace_dir%0d", i), dir, dexp[i]);
         chk($sformatf("trace_busy%0d", i), busy, 1);
         chk($sformatf("trace_done%0d", i), done, (i == 6) ? 1 : 0);
         @(negedge clk);
      end
      chk("trace_idle_busy", busy, 0);
      chk("trace_idle_q", q, 2);
      chk("trace_idle_dir", dir, 1);

      // table of sweeps and rejected starts
      foreach (tbl[i]) begin
         run_vec(tbl[i].lo, tbl[i].hi, tbl[i].p, nb, nd, ne, da);
         chk($sformatf("vec%0d_busy", i), nb, tbl[i].exp_busy);
         chk($sformatf("vec%0d_done", i), nd, tbl[i].exp_done);
         chk($sformatf("vec%0d_err", i), ne, tbl[i].exp_err);
         chk($sformatf("vec%0d_q", i), q, tbl[i].exp_q);
         if (tbl[i].exp_done == 1) chk($sformatf("vec%0d_done_last", i), da, nb);
      end

      // abort in UP at q=9
      @(negedge clk);
      lo = 4'd0; hi = 4'd15; passes = 3'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (q == 4'd9 && dir) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("abort_reach_q9", found, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_q", q, 9);
      chk("abort_dir", dir, 1);
      chk("abort_done", done, 0);
      // start masked by abort in IDLE, including a bad config
      lo = 4'd1; hi = 4'd3; passes = 3'd1; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_q", q, 9);
      lo = 4'd5; hi = 4'd5;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("abort_idle_err", err, 0);
      chk("abort_idle_q2", q, 9);

      // async reset mid-DOWN at q=6
      @(negedge clk);
      lo = 4'd2; hi = 4'd8; passes = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (q == 4'd6 && !dir && busy) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("arst_reach_q6", found, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_q", q, 0);
      chk("arst_busy", busy, 0);
      chk("arst_dir", dir, 1);
      @(negedge clk);
      reset = 1'b1;
      run_vec(4'd2, 4'd5, 3'd1, nb, nd, ne, da);
      chk("arst_after_busy", nb, 7);
      chk("arst_after_done", nd, 1);
      chk("arst_after_q", q, 2);

`ifdef SWEEP_HOLD_EN
      // hold three cycles at q=3 in UP
      @(negedge clk);
      lo = 4'd1; hi = 4'd4; passes = 3'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nb = 0;
      for (int c = 0; c < 30; c++) begin
         if (c >= 2 && c <= 5) begin
            chk($sformatf("hold_q%0d", c), q, 3);
            chk($sformatf("hold_busy%0d", c), busy, 1);
         end
         if (busy) nb++;
         hold = (c >= 2 && c <= 4);
         if (!busy && c > 0) break;
         @(negedge clk);
      end
      hold = 1'b0;
      chk("hold_busy_total", nb, 10);
      chk("hold_final_q", q, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
